// File: rtl/uart_seq_pkg.sv
// Shared opcodes, stall modes, FSM states and LFSR taps for the UART test sequencer.
package uart_seq_pkg;

    localparam logic [1:0] OP_SEND       = 2'd0;
    localparam logic [1:0] OP_EXPECT     = 2'd1;
    localparam logic [1:0] OP_WAIT       = 2'd2;
    localparam logic [1:0] OP_EXPECT_ANY = 2'd3;

    localparam logic [1:0] STALL_OFF    = 2'd0;
    localparam logic [1:0] STALL_TOGGLE = 2'd1;
    localparam logic [1:0] STALL_LFSR   = 2'd2;
    localparam logic [1:0] STALL_HIGH   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_WAIT = 2'd3
    } seq_state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/uart_seq_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit for full/empty.
module uart_seq_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_empty;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_wr_en && !w_full)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (i_rd_en && !w_empty)
                r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !w_full)
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rptr[AW-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

// File: rtl/uart_test_sequencer.sv
// Scripted UART exerciser: command FIFO, send/expect/wait FSM, status and CPU stall generator.
// Optional: define UART_SEQ_LFSR_EN to make stall mode 2 pseudo-random.
module uart_test_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TIMEOUT   = 1_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [9:0] CmdIn,
    input  logic       CmdValid,
    output logic       CmdReady,
    output logic [7:0] TxData,
    output logic       TxValid,
    input  logic       TxReady,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    output logic       RxReady,
    input  logic [1:0] StallMode,
    output logic       Stall,
    output logic       Busy,
    output logic       Pass,
    output logic [7:0] ErrCount,
    output logic       TimeoutFlag,
    output logic [7:0] LastRx
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    seq_state_t     r_state;
    logic [1:0]     r_op;
    logic [7:0]     r_arg;
    logic           r_tx_valid;
    logic           r_rx_ready;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_wait_cnt;
    logic [7:0]     r_err;
    logic [7:0]     r_last_rx;
    logic           r_tflag;
    logic           r_stall;

    logic [9:0]     w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_busy;
    logic           w_lfsr_bit;

    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    uart_seq_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_wr_en   (CmdValid),
        .i_wr_data (CmdIn),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_SEND;
            r_arg      <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b0;
            r_timer    <= '0;
            r_wait_cnt <= '0;
            r_err      <= '0;
            r_last_rx  <= '0;
            r_tflag    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_op  <= w_head[9:8];
                        r_arg <= w_head[7:0];
                        case (w_head[9:8])
                            OP_SEND: begin
                                r_state    <= ST_SEND;
                                r_tx_valid <= 1'b1;
                            end
                            OP_WAIT: begin
                                r_state    <= ST_WAIT;
                                r_wait_cnt <= w_head[7:0];
                            end
                            default: begin
                                r_state    <= ST_RECV;
                                r_rx_ready <= 1'b1;
                                r_timer    <= '0;
                            end
                        endcase
                    end
                end
                ST_SEND: begin
                    if (TxReady) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    // A byte arriving on the last timer cycle wins over the timeout
                    if (RxValid) begin
                        r_last_rx  <= RxData;
                        r_rx_ready <= 1'b0;
                        r_state    <= ST_IDLE;
                        if (r_op == OP_EXPECT && RxData != r_arg && r_err != 8'hFF)
                            r_err <= r_err + 8'd1;
                    end else if (r_timer == TIMER_LAST) begin
                        r_tflag    <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_state    <= ST_IDLE;
                        if (r_err != 8'hFF)
                            r_err <= r_err + 8'd1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 8'd0)
                        r_state <= ST_IDLE;
                    else
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_SEQ_LFSR_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge Clock) begin
        if (Reset)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign w_lfsr_bit = r_lfsr[0];
`else
    logic w_unused_seed;
    assign w_unused_seed = ^LFSR_SEED;
    assign w_lfsr_bit    = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stall <= 1'b0;
        end else begin
            case (StallMode)
                STALL_TOGGLE: r_stall <= ~r_stall;
                STALL_LFSR:   r_stall <= w_lfsr_bit;
                STALL_HIGH:   r_stall <= 1'b1;
                default:      r_stall <= 1'b0;
            endcase
        end
    end

    assign w_busy      = (r_state != ST_IDLE) || !w_empty;
    assign CmdReady    = !w_full;
    assign TxData      = r_arg;
    assign TxValid     = r_tx_valid;
    assign RxReady     = r_rx_ready;
    assign Stall       = r_stall;
    assign Busy        = w_busy;
    assign Pass        = !w_busy && (r_err == 8'd0) && !r_tflag;
    assign ErrCount    = r_err;
    assign TimeoutFlag = r_tflag;
    assign LastRx      = r_last_rx;

endmodule

// File: tb/tb_uart_test_sequencer.sv
// Directed, table-driven bench for uart_test_sequencer (DEPTH=4, TIMEOUT=16).
module tb_uart_test_sequencer;

    localparam logic [1:0] C_SEND = 2'd0;
    localparam logic [1:0] C_EXP  = 2'd1;
    localparam logic [1:0] C_WAIT = 2'd2;
    localparam logic [1:0] C_ANY  = 2'd3;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [9:0] CmdIn;
    logic       CmdValid;
    logic       CmdReady;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;
    logic [1:0] StallMode;
    logic       Stall;
    logic       Busy;
    logic       Pass;
    logic [7:0] ErrCount;
    logic       TimeoutFlag;
    logic [7:0] LastRx;

    int n_checks = 0;
    int n_errors = 0;

    uart_test_sequencer #(.DEPTH(4), .TIMEOUT(16), .LFSR_SEED(SEED)) dut (
        .Clock(Clock), .Reset(Reset), .CmdIn(CmdIn), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .StallMode(StallMode), .Stall(Stall), .Busy(Busy), .Pass(Pass),
        .ErrCount(ErrCount), .TimeoutFlag(TimeoutFlag), .LastRx(LastRx)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        logic [7:0] rx;
        logic [7:0] exp_last;
        logic [7:0] exp_err;
        logic       exp_pass;
    } rx_vec_t;

    typedef struct {
        logic [1:0] mode;
        logic       exp;
    } st_vec_t;

    rx_vec_t rxv[5];
    st_vec_t stv[13];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        CmdValid = 1'b0;
        RxValid  = 1'b0;
        Reset    = 1'b1;
        tick();
        Reset    = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] arg);
        CmdIn    = {op, arg};
        CmdValid = 1'b1;
        tick();
        CmdValid = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  txq[$];
        logic [15:0] ref_lfsr;
        logic        exp_s;
        int          n;

        rxv[0] = '{C_EXP, 8'h41, 8'h41, 8'h41, 8'd0, 1'b1};
        rxv[1] = '{C_EXP, 8'h41, 8'h42, 8'h42, 8'd1, 1'b0};
        rxv[2] = '{C_ANY, 8'h00, 8'h5A, 8'h5A, 8'd1, 1'b0};
        rxv[3] = '{C_EXP, 8'h7E, 8'h7E, 8'h7E, 8'd1, 1'b0};
        rxv[4] = '{C_EXP, 8'h00, 8'hFF, 8'hFF, 8'd2, 1'b0};

        stv[0]  = '{2'd3, 1'b1};
        stv[1]  = '{2'd0, 1'b0};
        stv[2]  = '{2'd1, 1'b1};
        stv[3]  = '{2'd1, 1'b0};
        stv[4]  = '{2'd1, 1'b1};
        stv[5]  = '{2'd1, 1'b0};
        stv[6]  = '{2'd1, 1'b1};
        stv[7]  = '{2'd1, 1'b0};
        stv[8]  = '{2'd1, 1'b1};
        stv[9]  = '{2'd1, 1'b0};
        stv[10] = '{2'd3, 1'b1};
        stv[11] = '{2'd1, 1'b0};
        stv[12] = '{2'd0, 1'b0};

        CmdIn = '0; CmdValid = 0; TxReady = 0; RxData = '0; RxValid = 0; StallMode = 2'd0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;

        check("rst_busy", Busy, 0);
        check("rst_pass", Pass, 1);
        check("rst_cmdready", CmdReady, 1);
        check("rst_txvalid", TxValid, 0);
        check("rst_rxready", RxReady, 0);
        check("rst_err", ErrCount, 0);
        check("rst_lastrx", LastRx, 0);
        check("rst_tflag", TimeoutFlag, 0);
        check("rst_stall", Stall, 0);

        // SEND latency and single-cycle handshake
        TxReady = 1'b1;
        push(C_SEND, 8'hFF);
        check("send_c1_txvalid", TxValid, 0);
        check("send_c1_busy", Busy, 1);
        tick();
        check("send_c2_txvalid", TxValid, 1);
        check("send_c2_txdata", TxData, 8'hFF);
        tick();
        check("send_c3_txvalid", TxValid, 0);
        tick();
        check("send_idle_busy", Busy, 0);

        for (int i = 0; i < 5; i++) begin
            push(rxv[i].op, rxv[i].arg);
            n = 0;
            while (!RxReady && n < 20) begin tick(); n++; end
            check($sformatf("rx%0d_rxready", i), RxReady, 1);
            RxData  = rxv[i].rx;
            RxValid = 1'b1;
            tick();
            RxValid = 1'b0;
            n = 0;
            while (Busy && n < 20) begin tick(); n++; end
            check($sformatf("rx%0d_busy", i), Busy, 0);
            check($sformatf("rx%0d_rxready_off", i), RxReady, 0);
            check($sformatf("rx%0d_lastrx", i), LastRx, rxv[i].exp_last);
            check($sformatf("rx%0d_err", i), ErrCount, rxv[i].exp_err);
            check($sformatf("rx%0d_pass", i), Pass, rxv[i].exp_pass);
        end

        // WAIT lasts arg+1 cycles
        do_reset();
        push(C_WAIT, 8'd3);
        repeat (4) tick();
        check("wait3_last_busy", Busy, 1);
        tick();
        check("wait3_done_busy", Busy, 0);
        push(C_WAIT, 8'd0);
        tick();
        check("wait0_busy", Busy, 1);
        tick();
        check("wait0_done_busy", Busy, 0);

        // Receive timeout after 16 RECV cycles
        push(C_EXP, 8'h33);
        tick();
        check("to_rxready_start", RxReady, 1);
        repeat (15) tick();
        check("to_rxready_16", RxReady, 1);
        check("to_tflag_pre", TimeoutFlag, 0);
        tick();
        check("to_tflag", TimeoutFlag, 1);
        check("to_err", ErrCount, 1);
        check("to_busy", Busy, 0);
        check("to_pass", Pass, 0);
        check("to_rxready_off", RxReady, 0);

        // Reset during a long WAIT with queued SENDs
        TxReady = 1'b1;
        push(C_WAIT, 8'd200);
        push(C_SEND, 8'hA1);
        push(C_SEND, 8'hA2);
        push(C_SEND, 8'hA3);
        repeat (5) tick();
        check("midwait_busy", Busy, 1);
        check("midwait_txvalid", TxValid, 0);
        do_reset();
        check("midrst_busy", Busy, 0);
        check("midrst_pass", Pass, 1);
        check("midrst_err", ErrCount, 0);
        check("midrst_tflag", TimeoutFlag, 0);
        check("midrst_cmdready", CmdReady, 1);
        check("midrst_lastrx", LastRx, 0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (TxValid) n++;
            tick();
        end
        check("midrst_no_send", n, 0);

        // FIFO fill with TxReady low, then drain in order
        TxReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("full_ready_%0d", k), CmdReady, 1);
            CmdIn    = {C_SEND, 8'h10 + 8'(k)};
            CmdValid = 1'b1;
            tick();
        end
        check("full_cmdready", CmdReady, 0);
        CmdIn = {C_SEND, 8'h99};
        tick();
        CmdValid = 1'b0;
        check("full_hold_cmdready", CmdReady, 0);
        TxReady = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (TxValid) txq.push_back(TxData);
            tick();
        end
        check("drain_count", txq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < txq.size())
                check($sformatf("drain_%0d", k), txq[k], 8'h10 + 8'(k));
        end
        check("drain_busy", Busy, 0);

        // Stall generator vectors
        do_reset();
        for (int i = 0; i < 13; i++) begin
            StallMode = stv[i].mode;
            tick();
            check($sformatf("stall_%0d", i), Stall, stv[i].exp);
        end

        // Mode 2 from reset against reference LFSR
        StallMode = 2'd2;
        do_reset();
        ref_lfsr = SEED;
        check("lfsr_rst_stall", Stall, 0);
        for (int i = 0; i < 16; i++) begin
`ifdef UART_SEQ_LFSR_EN
            exp_s = ref_lfsr[0];
`else
            exp_s = 1'b0;
`endif
            ref_lfsr = lfsr_step(ref_lfsr);
            tick();
            check($sformatf("lfsr_%0d", i), Stall, exp_s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
